debounce_filter: RTL and testbench

Conditions a noisy, asynchronous single-bit input (push-button, switch, or external strobe) into a clean, clock-synchronous level plus single-cycle edge pulses. It sits directly upstream of the FF_D register stage: `dout` drives the stage's `d` input, so that stage only ever samples a settled, glitch-free value. The input is synchronized through two flops, then accepted only after it has held a new value for `STABLE_CYCLES` consecutive clocks.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/debounce_filter.sv | 140 ++++++++++++++
 tb/tb_debounce_filter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce filter.
// Holds the FSM state encoding, the default qualification length and the counter width helper.
package debounce_pkg;

    localparam int unsigned DEB_STABLE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } deb_state_t;

    // Width needed to hold values 0..n
    function automatic int unsigned deb_cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both stages load RST_VAL under synchronous reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/debounce_filter.sv
// Debounces a raw asynchronous bit into a clean level plus one-cycle rise/fall pulses.
// A new synchronized value must persist STABLE_CYCLES consecutive clocks before dout follows it.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_DEF,
    parameter logic        RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int unsigned          CNT_W     = deb_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam deb_state_t           RST_STATE = RST_VAL ? STABLE_HI : STABLE_LO;

    logic             w_s2;
    deb_state_t       r_state;
    deb_state_t       w_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    logic             r_dout;
    logic             w_dout;
    logic             r_rise;
    logic             w_rise;
    logic             r_fall;
    logic             w_fall;
    logic             r_busy;
    logic             w_busy;

    sync_2ff #(
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_raw),
        .q   (w_s2)
    );

    // State, counter and output registers; reset wins over any same-cycle commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_dout  <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_dout  <= w_dout;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            r_busy  <= w_busy;
        end
    end

    // Next-state logic; any return to the old level during WAIT restarts from zero
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_dout  = r_dout;
        w_rise  = 1'b0;
        w_fall  = 1'b0;

        case (r_state)
            STABLE_LO: begin
                if (w_s2) begin
                    if (STABLE_CYCLES <= 1) begin
                        w_state = STABLE_HI;
                        w_dout  = 1'b1;
                        w_rise  = 1'b1;
                        w_cnt   = '0;
                    end else begin
                        w_state = WAIT_HI;
                        w_cnt   = CNT_W'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (!w_s2) begin
                    w_state = STABLE_LO;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state = STABLE_HI;
                    w_dout  = 1'b1;
                    w_rise  = 1'b1;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!w_s2) begin
                    if (STABLE_CYCLES <= 1) begin
                        w_state = STABLE_LO;
                        w_dout  = 1'b0;
                        w_fall  = 1'b1;
                        w_cnt   = '0;
                    end else begin
                        w_state = WAIT_LO;
                        w_cnt   = CNT_W'(1);
                    end
                end
            end
            WAIT_LO: begin
                if (w_s2) begin
                    w_state = STABLE_HI;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state = STABLE_LO;
                    w_dout  = 1'b0;
                    w_fall  = 1'b1;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = RST_STATE;
                w_cnt   = '0;
                w_dout  = RST_VAL;
            end
        endcase

        w_busy = (w_state == WAIT_HI) || (w_state == WAIT_LO);
    end

    assign dout       = r_dout;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: directed vector table, hand-written corner sequences and a random soak.
// Expected outputs are queued when stimulus is driven and compared after the following clock edge.
module tb_debounce_filter;

    localparam int unsigned SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_raw = 1'b0;
    logic dout;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    debounce_filter #(
        .STABLE_CYCLES (SC),
        .RST_VAL       (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_raw    (din_raw),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected vector packs {dout, rise_pulse, fall_pulse, busy}
    typedef struct packed {
        logic       rst;
        logic       din;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         step_no  = 0;
    int         rise_seen;
    int         fall_seen;

    // Reference: counts consecutive synchronized samples differing from the output level
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_dout = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;
    int   m_run = 0;

    task automatic model_step(input logic r, input logic d, output logic [3:0] e);
        logic old_s2;
        old_s2 = m_s2;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        end else begin
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (old_s2 != m_dout) begin
                m_run = m_run + 1;
                if (m_run == int'(SC)) begin
                    m_dout = old_s2;
                    m_rise = old_s2;
                    m_fall = !old_s2;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = d;
        end
        e = {m_dout, m_rise, m_fall, (m_run != 0)};
    endtask

    task automatic check(input string name);
        logic [3:0] got;
        logic [3:0] exp;
        got = {dout, rise_pulse, fall_pulse, busy};
        exp = sb_q.pop_front();
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s step %0d: dout/rise/fall/busy got %b expected %b", name, step_no, got, exp);
    endtask

    task automatic apply(input logic r, input logic d, input logic [3:0] e, input string name);
        @(negedge clk);
        rst     = r;
        din_raw = d;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        if (rise_pulse) rise_seen++;
        if (fall_pulse) fall_seen++;
        check(name);
    endtask

    task automatic mstep(input logic r, input logic d, input string name);
        logic [3:0] e;
        model_step(r, d, e);
        apply(r, d, e, name);
    endtask

    task automatic check_count(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic add(input logic r, input logic d, input logic [3:0] e);
        vec_t v;
        v.rst = r; v.din = d; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] me;
        logic       d;
        logic       bounce[7];

        // Reset with din high, then release with din low
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 4'b0000);
        // Clean rise: busy for three edges, commit on the sixth edge
        add(1'b0, 1'b1, 4'b0000); add(1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 4'b0001); add(1'b0, 1'b1, 4'b0001);
        add(1'b0, 1'b1, 4'b0001); add(1'b0, 1'b1, 4'b1100);
        add(1'b0, 1'b1, 4'b1000); add(1'b0, 1'b1, 4'b1000);
        // Clean fall
        add(1'b0, 1'b0, 4'b1000); add(1'b0, 1'b0, 4'b1000);
        add(1'b0, 1'b0, 4'b1001); add(1'b0, 1'b0, 4'b1001);
        add(1'b0, 1'b0, 4'b1001); add(1'b0, 1'b0, 4'b0010);
        add(1'b0, 1'b0, 4'b0000); add(1'b0, 1'b0, 4'b0000);
        // Three-cycle glitch is rejected
        add(1'b0, 1'b1, 4'b0000); add(1'b0, 1'b1, 4'b0000);
        add(1'b0, 1'b1, 4'b0001); add(1'b0, 1'b0, 4'b0001);
        add(1'b0, 1'b0, 4'b0001); add(1'b0, 1'b0, 4'b0000);
        add(1'b0, 1'b0, 4'b0000);

        rise_seen = 0;
        fall_seen = 0;
        foreach (tbl[i]) begin
            model_step(tbl[i].rst, tbl[i].din, me);
            apply(tbl[i].rst, tbl[i].din, tbl[i].exp, "table");
        end
        check_count("table_rise_count", rise_seen, 1);
        check_count("table_fall_count", fall_seen, 1);

        // Bounce during qualification restarts the count; one rise only
        bounce = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rise_seen = 0;
        fall_seen = 0;
        for (int i = 0; i < 7; i++) mstep(1'b0, bounce[i], "bounce");
        for (int i = 0; i < 6; i++) mstep(1'b0, 1'b1, "bounce_hold");
        check_count("bounce_rise_count", rise_seen, 1);
        check_count("bounce_dout", int'(dout), 1);

        // Clean fall from high
        rise_seen = 0;
        fall_seen = 0;
        for (int i = 0; i < 8; i++) mstep(1'b0, 1'b0, "fall");
        check_count("fall_rise_count", rise_seen, 0);
        check_count("fall_fall_count", fall_seen, 1);

        // Reset while qualifying a rise at cnt=2; qualification restarts after release
        rise_seen = 0;
        for (int i = 0; i < 4; i++) mstep(1'b0, 1'b1, "midq_pre");
        mstep(1'b1, 1'b1, "midq_reset");
        check_count("midq_busy_after_rst", int'(busy), 0);
        for (int i = 0; i < 5; i++) mstep(1'b0, 1'b1, "midq_requal");
        check_count("midq_no_early_rise", rise_seen, 0);
        for (int i = 0; i < 3; i++) mstep(1'b0, 1'b1, "midq_commit");
        check_count("midq_rise_count", rise_seen, 1);

        // Random soak with bursty toggling and occasional reset
        d = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4, 0) == 0) d = ~d;
            mstep(($urandom_range(99, 0) == 0), d, "random");
        end
        for (int i = 0; i < 8; i++) mstep(1'b0, d, "random_settle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
